// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM address and buffers fetched
// two-byte instructions in a small FIFO presented to the CPU over valid/ready.
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data1,
    input  logic [DATA_W-1:0] rom_data2,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_op1,
    output logic [DATA_W-1:0] instr_op2,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] op1_mem [DEPTH];
    logic [DATA_W-1:0] op2_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem  [DEPTH];

    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = !halt & !redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop);

    assign rom_address = pc_q;
    assign instr_op1   = op1_mem[rptr_q];
    assign instr_op2   = op2_mem[rptr_q];
    assign instr_pc    = pc_mem[rptr_q];

    always_comb begin
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (redirect_valid) begin
            // Flush discards everything, including an entry popped this cycle.
            pc_d    = redirect_pc;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + ADDR_W'(2);
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                op1_mem[i] <= '0;
                op2_mem[i] <= '0;
                pc_mem[i]  <= '0;
            end
        end else if (push) begin
            op1_mem[wptr_q] <= rom_data1;
            op2_mem[wptr_q] <= rom_data2;
            pc_mem[wptr_q]  <= pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural ROM plus hand-computed expected fetch stream.
module tb_instr_fetch;

    logic       clk;
    logic       reset;
    logic [7:0] rom_address;
    logic [7:0] rom_data1;
    logic [7:0] rom_data2;
    logic       halt;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op1;
    logic [7:0] instr_op2;
    logic [7:0] instr_pc;

    logic [7:0] rom [256];

    int vectors;
    int miscompares;

    instr_fetch #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .DEPTH   (2),
        .RESET_PC(8'd0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rom_address   (rom_address),
        .rom_data1     (rom_data1),
        .rom_data2     (rom_data2),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op1     (instr_op1),
        .instr_op2     (instr_op2),
        .instr_pc      (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rom_data1 = rom[rom_address];
        rom_data2 = (rom_address == 8'hFF) ? 8'h00 : rom[rom_address + 8'd1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input logic [7:0] pc, input logic [7:0] op1,
                             input logic [7:0] op2);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".pc"},    32'(instr_pc),    32'(pc));
        chk({tag, ".op1"},   32'(instr_op1),   32'(op1));
        chk({tag, ".op2"},   32'(instr_op2),   32'(op2));
    endtask

    logic [7:0] exp_pc  [7] = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12};
    logic [7:0] exp_op1 [7] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h80, 8'h33, 8'h20};
    logic [7:0] exp_op2 [7] = '{8'h00, 8'hFF, 8'h01, 8'hF8, 8'h13, 8'h82, 8'h73};

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        instr_ready    = 1'b0;

        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[0]  = 8'h00; rom[1]  = 8'h00; rom[2]  = 8'h10; rom[3]  = 8'hFF;
        rom[4]  = 8'h11; rom[5]  = 8'h01; rom[6]  = 8'h12; rom[7]  = 8'hF8;
        rom[8]  = 8'h80; rom[9]  = 8'h13; rom[10] = 8'h33; rom[11] = 8'h82;
        rom[12] = 8'h20; rom[13] = 8'h73; rom[254] = 8'hAB; rom[255] = 8'hCD;

        // Reset state.
        #12;
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.op1",   32'(instr_op1),   32'd0);
        chk("rst.op2",   32'(instr_op2),   32'd0);
        chk("rst.pc",    32'(instr_pc),    32'd0);
        chk("rst.addr",  32'(rom_address), 32'd0);

        // Streaming with ready held high.
        @(negedge clk);
        reset       = 1'b1;
        instr_ready = 1'b1;
        #1;
        chk("first.addr",  32'(rom_address), 32'd0);
        chk("first.valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_entry($sformatf("stream%0d", k), exp_pc[k], exp_op1[k], exp_op2[k]);
        end

        // Asynchronous reset mid-stream, between edges.
        #2;
        reset = 1'b0;
        #1;
        chk("async.valid", 32'(instr_valid), 32'd0);
        chk("async.addr",  32'(rom_address), 32'd0);
        chk("async.pc",    32'(instr_pc),    32'd0);

        // Backpressure: head holds, PC freezes at 4.
        instr_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_entry($sformatf("bp%0d", k), 8'd0, 8'h00, 8'h00);
            chk($sformatf("bp%0d.addr", k), 32'(rom_address), (k == 0) ? 32'd2 : 32'd4);
        end
        instr_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk_entry($sformatf("drain%0d", k), exp_pc[k], exp_op1[k], exp_op2[k]);
        end

        // Redirect to 12 with two entries queued and a pop in the same cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 8'd12;
        tick();
        redirect_valid = 1'b0;
        chk("redir12.valid", 32'(instr_valid), 32'd0);
        chk("redir12.addr",  32'(rom_address), 32'd12);
        tick();
        chk_entry("redir12.t0", 8'd12, 8'h20, 8'h73);
        tick();
        chk_entry("redir12.t1", 8'd14, 8'h54, 8'h55);

        // Redirect to 254: wraps to 0 afterwards.
        redirect_valid = 1'b1;
        redirect_pc    = 8'd254;
        tick();
        redirect_valid = 1'b0;
        chk("redir254.valid", 32'(instr_valid), 32'd0);
        chk("redir254.addr",  32'(rom_address), 32'd254);
        tick();
        chk_entry("redir254.t0", 8'd254, 8'hAB, 8'hCD);
        tick();
        chk_entry("redir254.t1", 8'd0, 8'h00, 8'h00);

        // Redirect to 255: second byte reads 0, next PC is 1.
        redirect_valid = 1'b1;
        redirect_pc    = 8'd255;
        tick();
        redirect_valid = 1'b0;
        chk("redir255.valid", 32'(instr_valid), 32'd0);
        tick();
        chk_entry("redir255.t0", 8'd255, 8'hCD, 8'h00);
        tick();
        chk_entry("redir255.t1", 8'd1, 8'h00, 8'h10);

        // Halt with two entries queued: drain, then PC holds.
        instr_ready = 1'b0;
        tick();
        chk_entry("prehalt", 8'd1, 8'h00, 8'h10);
        halt        = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk_entry("halt.d0", 8'd3, 8'hFF, 8'h11);
        tick();
        chk("halt.empty", 32'(instr_valid), 32'd0);
        chk("halt.addr0", 32'(rom_address), 32'd5);
        tick();
        chk("halt.idle",  32'(instr_valid), 32'd0);
        chk("halt.addr1", 32'(rom_address), 32'd5);
        halt = 1'b0;
        tick();
        chk_entry("resume.t0", 8'd5, 8'h01, 8'h12);
        tick();
        chk_entry("resume.t1", 8'd7, 8'hF8, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage between the instruction `ROM` and the `CPU` decode/execute logic. It owns the program counter, drives `rom_address`, and captures the two-byte instruction `{rom_data1, rom_data2}` that the ROM returns combinationally. Fetched instructions go into a small FIFO and are presented to the CPU over a valid/ready handshake. Control-flow redirects (jumps) flush the FIFO and restart fetch.

## Interface
- `ADDR_W`, default 8: PC / ROM address width.
- `DATA_W`, default 8: width of each opcode byte.
- `DEPTH`, default 2: number of instruction buffer entries (at least 2).
- `RESET_PC`, default 0: PC value loaded on reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting (0) clears state immediately; release is sampled on `clk`.
- `rom_address`  out  ADDR_W  current PC, driven straight from the PC register.
- `rom_data1`  in  DATA_W  ROM byte at `rom_address`, valid in the same cycle.
- `rom_data2`  in  DATA_W  ROM byte at `rom_address+1`, valid in the same cycle. The ROM returns 0 when the address is 255.
- `halt`  in  1  when 1, suppresses fetch (no push, PC holds).
- `redirect_valid`  in  1  one-cycle jump request.
- `redirect_pc`  in  ADDR_W  jump target.
- `instr_valid`  out  1  FIFO head holds an instruction.
- `instr_ready`  in  1  CPU accepts the head this cycle.
- `instr_op1`  out  DATA_W  head opcode byte 1.
- `instr_op2`  out  DATA_W  head opcode byte 2.
- `instr_pc`  out  ADDR_W  PC the head entry was fetched from.

## Operation
- All instructions are 2 bytes. The PC advances by 2 modulo 2^ADDR_W, so 254 goes to 0 and 255 goes to 1.
- Buffer state: a circular FIFO of DEPTH entries `{op1, op2, pc}`, with read/write pointers and an occupancy count from 0 to DEPTH.
- `pop` = `instr_valid & instr_ready`.
- `push` = `!halt & !redirect_valid & (count < DEPTH | pop)`.
- On push:
  - write `{rom_data1, rom_data2, rom_address}` at the write pointer;
  - PC <= PC + 2.
- When push and pop occur together, count is unchanged and both pointers advance. A full FIFO with a simultaneous pop still accepts the push.
- `instr_valid` = (count != 0). `instr_op1`, `instr_op2` and `instr_pc` are the head entry's fields. They stay stable while `instr_valid & !instr_ready`.
- Redirect (highest priority):
  - count <= 0 and pointers reset;
  - PC <= `redirect_pc`;
  - no push in that cycle.
  - A pop in the same cycle is a completed handshake from the CPU's side. Its entry is discarded along with the rest.
- `halt` blocks push and PC update only. Pops continue to drain the FIFO. A redirect during halt still flushes and loads the PC.
- Reset (asynchronous, any time):
  - PC = RESET_PC, count = 0, pointers = 0;
  - all entry storage cleared to 0, so `instr_valid`=0, `instr_op1`=`instr_op2`=0, `instr_pc`=0 and `rom_address`=RESET_PC.
  - Any in-flight entries are lost.

## Timing
- Fetch-to-valid latency is 1 cycle. The entry pushed at edge N is visible on `instr_*` with `instr_valid`=1 after edge N.
- First instruction after reset release: `rom_address`=RESET_PC during the first active cycle, and `instr_valid` rises after the first active edge.
- Redirect asserted in cycle N:
  - `rom_address` = `redirect_pc` in cycle N+1;
  - first target instruction valid in cycle N+2;
  - `instr_valid`=0 in cycle N+1.
- Steady state with `instr_ready` held at 1 and no halt: one instruction per cycle, with `instr_pc` incrementing by 2 each cycle.
- Backpressure: with `instr_ready`=0, the FIFO fills after DEPTH pushes, then `rom_address` freezes at PC = head PC + 2*DEPTH.
- No combinational path from `instr_ready` to `rom_address`. `rom_address` is a pure register output.

## Test plan
- Reset, then `instr_ready`=1 against the standard program: `instr_pc`/op1/op2 sequence is 0/00/00, 2/10/FF, 4/11/01, 6/12/F8, 8/80/13, 10/33/82, 12/20/73, on consecutive cycles after the first valid.
- Reset, then `instr_ready`=0 for 5 cycles: `instr_valid`=1 with pc 0 / 00 / 00 held constant, and `rom_address` stuck at 4. Raise ready: pc 0, 2, 4, ... delivered with no gap and no duplicate.
- In steady state, pulse `redirect_valid` with `redirect_pc`=12 while 2 entries are queued: `instr_valid`=0 the next cycle, then pc 12 / 20 / 73, then pc 14.
- Redirect to 254: entry pc 254 with op1=rom[254] and op2=rom[255], then pc 0 / 00 / 00. Redirect to 255: op2 = 00, next pc 1.
- `halt`=1 with 2 entries queued and ready=1: both drain, then `instr_valid`=0 and `rom_address` constant. Release halt: fetch resumes at the held PC.
- Assert `reset`=0 mid-stream, asynchronously between edges: `instr_valid`=0 and `rom_address`=0 immediately. After release, the sequence restarts at pc 0.
